// File: rtl/mb_word_seq_if.sv
`default_nettype none
//============================================================================
// Module      : mb_word_seq_if
// Description : Handshake/bus bundle between a memory-fill requester and the
//               MBOX word sequencer.
//               Requester -> sequencer : START, START_WD, NWORDS,
//                                         DATA_VALID, ADV
//               Sequencer -> requester : MB0..MB3_HOLD_IN, MB_SEL_2_EN,
//                                         MB_SEL_1_EN, MB_SEL_HOLD, BUSY,
//                                         DONE, NXM_ANY
// Revision    : 1.0 - initial release
//============================================================================
interface mb_word_seq_if;
    logic       START;
    logic [1:0] START_WD;
    logic [2:0] NWORDS;
    logic       DATA_VALID;
    logic       ADV;
    logic       MB0_HOLD_IN;
    logic       MB1_HOLD_IN;
    logic       MB2_HOLD_IN;
    logic       MB3_HOLD_IN;
    logic       MB_SEL_2_EN;
    logic       MB_SEL_1_EN;
    logic       MB_SEL_HOLD;
    logic       BUSY;
    logic       DONE;
    logic       NXM_ANY;

    // Sequencer side
    modport slave (
        input  START, START_WD, NWORDS, DATA_VALID, ADV,
        output MB0_HOLD_IN, MB1_HOLD_IN, MB2_HOLD_IN, MB3_HOLD_IN,
        output MB_SEL_2_EN, MB_SEL_1_EN, MB_SEL_HOLD, BUSY, DONE, NXM_ANY
    );

    // Requester / consumer side
    modport master (
        output START, START_WD, NWORDS, DATA_VALID, ADV,
        input  MB0_HOLD_IN, MB1_HOLD_IN, MB2_HOLD_IN, MB3_HOLD_IN,
        input  MB_SEL_2_EN, MB_SEL_1_EN, MB_SEL_HOLD, BUSY, DONE, NXM_ANY
    );
endinterface
`default_nettype wire

// File: rtl/mb_word_seq.sv
`default_nettype none
//============================================================================
// Module      : mb_word_seq
// Description : MBOX memory-buffer word sequencer. Steers up to four memory
//               words into MB0..MB3 starting at a given word number
//               (wrapping mod 4), then walks the MB output-mux select across
//               the same words as the consumer advances. A fill that sees no
//               word for TIMEOUT clocks aborts and sets the sticky NXM flag.
// Ports       : clk   - MBOX clock, all state changes on rising edge
//               rst_n - asynchronous active-low reset
//               mb    - mb_word_seq_if.slave bundle (request, data-valid,
//                       advance in; MB hold strobes, select, status out)
// Revision    : 1.0 - initial release
//============================================================================
module mb_word_seq #(
    parameter int TIMEOUT = 64           // legal 2..255
) (
    input  wire          clk,
    input  wire          rst_n,
    mb_word_seq_if.slave mb
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [7:0] c_tmo_last = 8'(TIMEOUT - 1);

    state_t     r_state;
    logic [1:0] r_ptr;       // MB receiving the next fill word
    logic [2:0] r_rem;       // fill words still expected
    logic [1:0] r_base;      // first word number of the transfer
    logic [2:0] r_nwords;    // effective word count, latched at START
    logic [7:0] r_tmo;       // FILL clocks since last word arrival
    logic [1:0] r_dptr;      // MB currently selected for the consumer
    logic [2:0] r_dcnt;      // words left to consume
    logic [1:0] r_sel;
    logic       r_sel_hold;
    logic       r_busy;
    logic       r_done;
    logic       r_nxm;

    logic [2:0] w_eff_nwords;
    logic       w_fill_wr;

    // Out-of-range counts (0, 5..7) run as a full four-word transfer.
    assign w_eff_nwords = ((mb.NWORDS == 3'd0) || (mb.NWORDS > 3'd4)) ? 3'd4 : mb.NWORDS;

    // Capture strobes are combinational so the addressed MB loads on the
    // same clock the word is on the bus.
    assign w_fill_wr      = (r_state == ST_FILL) && mb.DATA_VALID;
    assign mb.MB0_HOLD_IN = ~(w_fill_wr && (r_ptr == 2'd0));
    assign mb.MB1_HOLD_IN = ~(w_fill_wr && (r_ptr == 2'd1));
    assign mb.MB2_HOLD_IN = ~(w_fill_wr && (r_ptr == 2'd2));
    assign mb.MB3_HOLD_IN = ~(w_fill_wr && (r_ptr == 2'd3));

    assign mb.MB_SEL_2_EN = r_sel[1];
    assign mb.MB_SEL_1_EN = r_sel[0];
    assign mb.MB_SEL_HOLD = r_sel_hold;
    assign mb.BUSY        = r_busy;
    assign mb.DONE        = r_done;
    assign mb.NXM_ANY     = r_nxm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_ptr      <= 2'd0;
            r_rem      <= 3'd0;
            r_base     <= 2'd0;
            r_nwords   <= 3'd0;
            r_tmo      <= 8'd0;
            r_dptr     <= 2'd0;
            r_dcnt     <= 3'd0;
            r_sel      <= 2'd0;
            r_sel_hold <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_nxm      <= 1'b0;
        end else begin
            // Select-load and DONE are single-clock pulses.
            r_done     <= 1'b0;
            r_sel_hold <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (mb.START) begin
                        r_state  <= ST_FILL;
                        r_busy   <= 1'b1;
                        r_ptr    <= mb.START_WD;
                        r_base   <= mb.START_WD;
                        r_rem    <= w_eff_nwords;
                        r_nwords <= w_eff_nwords;
                        r_tmo    <= 8'd0;
                        r_nxm    <= 1'b0;
                    end
                end

                ST_FILL: begin
                    if (mb.DATA_VALID) begin
                        r_ptr <= r_ptr + 2'd1;
                        r_rem <= r_rem - 3'd1;
                        r_tmo <= 8'd0;
                        if (r_rem == 3'd1) begin
                            // Last word in: present the first word to the
                            // consumer on the first DRAIN clock.
                            r_state    <= ST_DRAIN;
                            r_dptr     <= r_base;
                            r_dcnt     <= r_nwords;
                            r_sel      <= r_base;
                            r_sel_hold <= 1'b0;
                        end
                    end else if (r_tmo == c_tmo_last) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_nxm   <= 1'b1;
                        r_tmo   <= 8'd0;
                    end else begin
                        r_tmo <= r_tmo + 8'd1;
                    end
                end

                ST_DRAIN: begin
                    if (mb.ADV) begin
                        if (r_dcnt > 3'd1) begin
                            r_dptr     <= r_dptr + 2'd1;
                            r_sel      <= r_dptr + 2'd1;
                            r_sel_hold <= 1'b0;
                            r_dcnt     <= r_dcnt - 3'd1;
                        end else begin
                            // Final word consumed; select stays where it is.
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_dcnt  <= 3'd0;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mb_word_seq.sv
`default_nettype none
//============================================================================
// Module      : tb_mb_word_seq
// Description : Directed self-checking bench for mb_word_seq (TIMEOUT=8).
// Revision    : 1.0 - initial release
//============================================================================
module tb_mb_word_seq;

    logic clk = 1'b0;
    logic rst_n;
    int   n_pass  = 0;
    int   n_total = 0;

    mb_word_seq_if mbif();

    mb_word_seq #(.TIMEOUT(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mb    (mbif)
    );

    always #5 clk = ~clk;

    // Safety net against a stuck run.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    function automatic logic [3:0] holds();
        return {mbif.MB3_HOLD_IN, mbif.MB2_HOLD_IN, mbif.MB1_HOLD_IN, mbif.MB0_HOLD_IN};
    endfunction

    function automatic logic [3:0] sel();
        return {2'b00, mbif.MB_SEL_2_EN, mbif.MB_SEL_1_EN};
    endfunction

    // {BUSY, DONE, NXM_ANY, MB_SEL_HOLD}
    function automatic logic [3:0] stat();
        return {mbif.BUSY, mbif.DONE, mbif.NXM_ANY, mbif.MB_SEL_HOLD};
    endfunction

    initial begin
        rst_n           = 1'b0;
        mbif.START      = 1'b0;
        mbif.START_WD   = 2'd0;
        mbif.NWORDS     = 3'd0;
        mbif.DATA_VALID = 1'b0;
        mbif.ADV        = 1'b0;
        tick(); tick();
        chk("rst_holds", holds(), 4'b1111);
        chk("rst_sel",   sel(),   4'b0000);
        chk("rst_stat",  stat(),  4'b0001);
        rst_n = 1'b1;

        // ---- 4-word fill from word 2, wrap 3->0 ----
        mbif.START = 1'b1; mbif.START_WD = 2'd2; mbif.NWORDS = 3'd4;
        tick();
        mbif.START = 1'b0;
        chk("a_busy", stat(), 4'b1001);
        mbif.DATA_VALID = 1'b1; #1;
        chk("a_w0", holds(), 4'b1011); tick();
        chk("a_w1", holds(), 4'b0111); tick();
        chk("a_w2", holds(), 4'b1110); tick();
        chk("a_w3", holds(), 4'b1101); tick();
        // DATA_VALID still high in DRAIN must not strobe any MB.
        chk("a_dv_drain", holds(), 4'b1111);
        chk("a_sel0",  sel(),  4'b0010);
        chk("a_stat0", stat(), 4'b1000);
        mbif.DATA_VALID = 1'b0;
        mbif.ADV = 1'b1;
        tick(); chk("a_sel1", sel(), 4'b0011); chk("a_st1", stat(), 4'b1000);
        tick(); chk("a_sel2", sel(), 4'b0000);
        tick(); chk("a_sel3", sel(), 4'b0001);
        tick();
        chk("a_done", stat(), 4'b0101);
        chk("a_sel_kept", sel(), 4'b0001);
        mbif.ADV = 1'b0;
        tick(); chk("a_done_pulse", stat(), 4'b0001);

        // ---- single word at MB1 ----
        mbif.START = 1'b1; mbif.START_WD = 2'd1; mbif.NWORDS = 3'd1;
        tick();
        mbif.START = 1'b0;
        mbif.DATA_VALID = 1'b1; #1;
        chk("b_w0", holds(), 4'b1101);
        tick();
        mbif.DATA_VALID = 1'b0;
        chk("b_sel",  sel(),  4'b0001);
        chk("b_stat", stat(), 4'b1000);
        tick(); chk("b_idle_drain", stat(), 4'b1001);
        mbif.ADV = 1'b1;
        tick();
        mbif.ADV = 1'b0;
        chk("b_done", stat(), 4'b0101);
        chk("b_sel_kept", sel(), 4'b0001);

        // ---- timeout / NXM ----
        mbif.START = 1'b1; mbif.START_WD = 2'd0; mbif.NWORDS = 3'd2;
        tick();
        mbif.START = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("c_pre_tmo", stat(), 4'b1001);
        tick();
        chk("c_nxm", stat(), 4'b0011);
        tick();
        chk("c_nxm_sticky", stat(), 4'b0011);

        // ---- gapped 3-word fill from word 3; START during FILL/DRAIN ignored ----
        mbif.START = 1'b1; mbif.START_WD = 2'd3; mbif.NWORDS = 3'd3;
        tick();
        mbif.START = 1'b0;
        chk("d_nxm_clr", stat(), 4'b1001);
        mbif.START_WD = 2'd0;
        mbif.DATA_VALID = 1'b1; #1;
        chk("d_w0", holds(), 4'b0111); tick();
        mbif.DATA_VALID = 1'b0;
        tick();
        mbif.START = 1'b1; tick(); mbif.START = 1'b0;
        tick();
        mbif.DATA_VALID = 1'b1; #1;
        chk("d_w1", holds(), 4'b1110); tick();
        mbif.DATA_VALID = 1'b0;
        tick(); tick(); tick();
        chk("d_no_nxm", stat(), 4'b1001);
        mbif.DATA_VALID = 1'b1; #1;
        chk("d_w2", holds(), 4'b1101); tick();
        mbif.DATA_VALID = 1'b0;
        chk("d_sel0", sel(), 4'b0011);
        mbif.START = 1'b1; tick(); mbif.START = 1'b0;
        chk("d_start_drain", stat(), 4'b1001);
        chk("d_sel_held", sel(), 4'b0011);
        mbif.ADV = 1'b1;
        tick(); chk("d_sel1", sel(), 4'b0000);
        tick(); chk("d_sel2", sel(), 4'b0001);
        tick(); chk("d_done", stat(), 4'b0101);
        mbif.ADV = 1'b0;
        tick();

        // ---- reset mid-DRAIN, then NWORDS=0 runs as 4 ----
        mbif.START = 1'b1; mbif.START_WD = 2'd0; mbif.NWORDS = 3'd4;
        tick();
        mbif.START = 1'b0;
        mbif.DATA_VALID = 1'b1;
        tick(); tick(); tick(); tick();
        mbif.DATA_VALID = 1'b0;
        mbif.ADV = 1'b1;
        tick(); tick();
        mbif.ADV = 1'b0;
        chk("e_sel_mid", sel(), 4'b0010);
        #2 rst_n = 1'b0; #1;
        chk("e_rst_holds", holds(), 4'b1111);
        chk("e_rst_sel",   sel(),   4'b0000);
        chk("e_rst_stat",  stat(),  4'b0001);
        #2 rst_n = 1'b1;
        mbif.START = 1'b1; mbif.START_WD = 2'd1; mbif.NWORDS = 3'd0;
        tick();
        mbif.START = 1'b0;
        mbif.DATA_VALID = 1'b1; #1;
        chk("e_w0", holds(), 4'b1101); tick();
        chk("e_w1", holds(), 4'b1011); tick();
        chk("e_w2", holds(), 4'b0111); tick();
        chk("e_w3", holds(), 4'b1110); tick();
        mbif.DATA_VALID = 1'b0;
        chk("e_sel0", sel(), 4'b0001);
        mbif.ADV = 1'b1;
        tick(); chk("e_sel1", sel(), 4'b0010);
        tick(); chk("e_sel2", sel(), 4'b0011);
        tick(); chk("e_sel3", sel(), 4'b0000);
        tick(); chk("e_done", stat(), 4'b0101);
        mbif.ADV = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
